// File: rtl/sistema_cpu1_mul_pkg.sv
// Shared definitions for the CPU multiply combine path.
//   MUL_W / HALF_W : product word width and half-word width
//   MUL_TAG_W      : default destination-tag width (mul_tag_t)
//   stage_state_t  : occupancy of one pipeline register slice
//   mul_combine()  : low 32-bit product word from the three partial products
package sistema_cpu1_mul_pkg;

  localparam int MUL_W     = 32;
  localparam int HALF_W    = 16;
  localparam int MUL_TAG_W = 5;

  typedef logic [MUL_TAG_W-1:0] mul_tag_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  // Only the low halves of the cross products reach the low word; their
  // upper halves and the carry out of the mid sum land at bit 32 or above.
  function automatic logic [MUL_W-1:0] mul_combine(
    input logic [MUL_W-1:0] p1,
    input logic [MUL_W-1:0] p2,
    input logic [MUL_W-1:0] p3
  );
    logic [HALF_W-1:0] mid;
    mid = p2[HALF_W-1:0] + p3[HALF_W-1:0];
    return p1 + {mid, {HALF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/sistema_cpu1_mul_pipe_stage.sv
// Generic valid/ready register slice with synchronous flush.
//   clk, reset_n      : clock, async active-low reset
//   i_valid/o_ready   : upstream handshake (o_ready = empty or downstream taking)
//   i_data [W]        : payload captured on upstream handshake
//   i_flush           : drop held payload and any payload offered this cycle
//   o_valid/i_ready   : downstream handshake
//   o_data [W]        : held payload, stable while o_valid && !i_ready
//
// state    | meaning
// ST_EMPTY | no payload held, always ready
// ST_FULL  | payload held and presented on o_data
module sistema_cpu1_mul_pipe_stage
  import sistema_cpu1_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  stage_state_t r_state;
  stage_state_t w_state_nxt;
  logic [W-1:0] r_data;
  logic         w_load;

  // Ready does not look at i_valid, so upstream may use it to decide stalls.
  assign o_ready = (r_state == ST_EMPTY) || i_ready;
  assign w_load  = i_valid && o_ready && !i_flush;
  assign o_valid = (r_state == ST_FULL);
  assign o_data  = r_data;

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
        ST_FULL: begin
          if (w_load)       w_state_nxt = ST_FULL;
          else if (i_ready) w_state_nxt = ST_EMPTY;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload survives a flush; only the occupancy is cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/sistema_cpu1_cpu_mul_combine.sv
// Combines the multiplier cell's registered 16x16 partial products into the
// low 32-bit product word and hands it to writeback.
//   clk, reset_n                 : CPU clock, async active-low reset
//   M_mul_valid/M_mul_ready      : M-stage handshake (ready low stalls M)
//   M_mul_tag                    : destination register of the multiply
//   M_mul_cell_p1/p2/p3          : a_lo*b_lo, a_lo*b_hi, a_hi*b_lo
//   A_kill                       : flush every in-flight product
//   W_mul_valid/W_mul_ready      : writeback handshake
//   W_mul_result, W_mul_tag      : low product word and its tag
//   mul_done_cnt                 : saturating count of consumed results
// Stage 1 reduces the cross products to a 16-bit mid sum; the final add
// sits between stage 1 and the output slice.
module sistema_cpu1_cpu_mul_combine
  import sistema_cpu1_mul_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             M_mul_valid,
  output logic             M_mul_ready,
  input  logic [TAG_W-1:0] M_mul_tag,
  input  logic [MUL_W-1:0] M_mul_cell_p1,
  input  logic [MUL_W-1:0] M_mul_cell_p2,
  input  logic [MUL_W-1:0] M_mul_cell_p3,
  input  logic             A_kill,
  output logic             W_mul_valid,
  input  logic             W_mul_ready,
  output logic [MUL_W-1:0] W_mul_result,
  output logic [TAG_W-1:0] W_mul_tag,
  output logic [CNT_W-1:0] mul_done_cnt
);

  localparam int S1_W = TAG_W + MUL_W + HALF_W;
  localparam int S2_W = TAG_W + MUL_W;

  logic [HALF_W-1:0] w_m_mid;
  logic [S1_W-1:0]   w_s1_d;
  logic [S1_W-1:0]   w_s1_q;
  logic              w_s1_valid;
  logic              w_s2_ready;
  logic [TAG_W-1:0]  w_s1_tag;
  logic [MUL_W-1:0]  w_s1_lo;
  logic [HALF_W-1:0] w_s1_mid;
  logic [MUL_W-1:0]  w_s1_sum;
  logic [S2_W-1:0]   w_s2_d;
  logic [S2_W-1:0]   w_s2_q;
  logic              w_unused_hi;
  logic [CNT_W-1:0]  r_cnt;

  // Upper halves of the cross products only affect bits >= 32.
  assign w_unused_hi = ^{M_mul_cell_p2[MUL_W-1:HALF_W], M_mul_cell_p3[MUL_W-1:HALF_W]};

  // Carry out of the mid sum is deliberately dropped (it is bit 32).
  assign w_m_mid = M_mul_cell_p2[HALF_W-1:0] + M_mul_cell_p3[HALF_W-1:0];
  assign w_s1_d  = {M_mul_tag, M_mul_cell_p1, w_m_mid};

  sistema_cpu1_mul_pipe_stage #(.W(S1_W)) u_s1 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (M_mul_valid),
    .o_ready (M_mul_ready),
    .i_data  (w_s1_d),
    .i_flush (A_kill),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_q)
  );

  assign w_s1_tag = w_s1_q[S1_W-1 -: TAG_W];
  assign w_s1_lo  = w_s1_q[HALF_W +: MUL_W];
  assign w_s1_mid = w_s1_q[HALF_W-1:0];
  assign w_s1_sum = w_s1_lo + {w_s1_mid, {HALF_W{1'b0}}};
  assign w_s2_d   = {w_s1_tag, w_s1_sum};

  sistema_cpu1_mul_pipe_stage #(.W(S2_W)) u_s2 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_d),
    .i_flush (A_kill),
    .o_valid (W_mul_valid),
    .i_ready (W_mul_ready),
    .o_data  (w_s2_q)
  );

  assign W_mul_result = w_s2_q[MUL_W-1:0];
  assign W_mul_tag    = w_s2_q[S2_W-1 -: TAG_W];

  // A handshake completing in a kill cycle still counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (W_mul_valid && W_mul_ready && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign mul_done_cnt = r_cnt;

endmodule

// File: tb/tb_sistema_cpu1_cpu_mul_combine.sv
module tb_sistema_cpu1_cpu_mul_combine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        M_mul_valid = 1'b0;
  logic [4:0]  M_mul_tag = '0;
  logic [31:0] M_mul_cell_p1 = '0;
  logic [31:0] M_mul_cell_p2 = '0;
  logic [31:0] M_mul_cell_p3 = '0;
  logic        A_kill = 1'b0;
  logic        W_mul_ready = 1'b0;

  logic        M_mul_ready, W_mul_valid;
  logic [31:0] W_mul_result;
  logic [4:0]  W_mul_tag;
  logic [15:0] mul_done_cnt;

  logic        s_M_mul_ready, s_W_mul_valid;
  logic [31:0] s_W_mul_result;
  logic [4:0]  s_W_mul_tag;
  logic [3:0]  s_mul_done_cnt;

  always #5 clk = ~clk;

  sistema_cpu1_cpu_mul_combine dut (
    .clk(clk), .reset_n(reset_n),
    .M_mul_valid(M_mul_valid), .M_mul_ready(M_mul_ready), .M_mul_tag(M_mul_tag),
    .M_mul_cell_p1(M_mul_cell_p1), .M_mul_cell_p2(M_mul_cell_p2), .M_mul_cell_p3(M_mul_cell_p3),
    .A_kill(A_kill), .W_mul_valid(W_mul_valid), .W_mul_ready(W_mul_ready),
    .W_mul_result(W_mul_result), .W_mul_tag(W_mul_tag), .mul_done_cnt(mul_done_cnt)
  );

  sistema_cpu1_cpu_mul_combine #(.TAG_W(5), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .M_mul_valid(M_mul_valid), .M_mul_ready(s_M_mul_ready), .M_mul_tag(M_mul_tag),
    .M_mul_cell_p1(M_mul_cell_p1), .M_mul_cell_p2(M_mul_cell_p2), .M_mul_cell_p3(M_mul_cell_p3),
    .A_kill(A_kill), .W_mul_valid(s_W_mul_valid), .W_mul_ready(W_mul_ready),
    .W_mul_result(s_W_mul_result), .W_mul_tag(s_W_mul_tag), .mul_done_cnt(s_mul_done_cnt)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } item_t;

  // Reference model: ordered list of products in flight, whether the oldest
  // one is being presented to writeback, and the number of consumed results.
  item_t q[$];
  bit    m_out;
  int    m_cnt;
  int    n_cmp;
  int    n_fail;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_outputs();
    int c16, c4;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c4  = (m_cnt > 15) ? 15 : m_cnt;
    chk("w_valid", {31'b0, W_mul_valid}, {31'b0, m_out});
    if (m_out) begin
      chk("w_result", W_mul_result, q[0].res);
      chk("w_tag", {27'b0, W_mul_tag}, {27'b0, q[0].tag});
    end
    chk("done_cnt", {16'b0, mul_done_cnt}, c16[31:0]);
    chk("done_cnt_sat", {28'b0, s_mul_done_cnt}, c4[31:0]);
    chk("sat_w_valid", {31'b0, s_W_mul_valid}, {31'b0, m_out});
  endtask

  // One clock cycle: drive operands a,b as partial products, check ready,
  // advance the model across the edge, then check the registered outputs.
  task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input bit wr, input bit kill, output bit acc);
    bit    s1_has, adv, rdy, cons;
    item_t it;
    M_mul_valid   = v;
    M_mul_tag     = tag;
    M_mul_cell_p1 = {16'b0, a[15:0]} * {16'b0, b[15:0]};
    M_mul_cell_p2 = {16'b0, a[15:0]} * {16'b0, b[31:16]};
    M_mul_cell_p3 = {16'b0, a[31:16]} * {16'b0, b[15:0]};
    W_mul_ready   = wr;
    A_kill        = kill;
    #1;
    s1_has = (q.size() > (m_out ? 1 : 0));
    adv    = s1_has && (!m_out || wr);
    rdy    = !s1_has || adv;
    cons   = m_out && wr;
    chk("m_ready", {31'b0, M_mul_ready}, {31'b0, rdy});
    acc = v && M_mul_ready && !kill;
    it.res = a * b;
    it.tag = tag;
    if (cons) m_cnt++;
    if (kill) begin
      q.delete();
      m_out = 1'b0;
    end else begin
      if (cons) void'(q.pop_front());
      m_out = adv || (m_out && !cons);
      if (v && rdy) q.push_back(it);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    bit acc;
    int n_acc, idx;
    logic [31:0] ra [3];
    logic [31:0] rb [3];
    logic [31:0] held;
    n_cmp = 0;
    n_fail = 0;
    model_reset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_valid", {31'b0, W_mul_valid}, 32'd0);
    chk("rst_w_result", W_mul_result, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_m_ready", {31'b0, M_mul_ready}, 32'd1);

    // Basic product 0x12345 * 0x10002, tag 3, two-cycle latency
    cyc(1, 32'h00012345, 32'h00010002, 5'd3, 0, 0, acc);
    chk("basic_p2", M_mul_cell_p2, 32'h00002345);
    chk("basic_lat1", {31'b0, W_mul_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, acc);
    chk("basic_valid", {31'b0, W_mul_valid}, 32'd1);
    chk("basic_result", W_mul_result, 32'h2347468A);
    chk("basic_tag", {27'b0, W_mul_tag}, 32'd3);

    // Wrap/carry: -1 * -1
    cyc(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1, 0, acc);
    cyc(0, 0, 0, 0, 1, 0, acc);
    chk("wrap_result", W_mul_result, 32'h00000001);
    chk("wrap_tag", {27'b0, W_mul_tag}, 32'd9);

    // Async reset mid-stream with products in flight
    cyc(1, $urandom, $urandom, 5'd1, 0, 0, acc);
    cyc(1, $urandom, $urandom, 5'd2, 0, 0, acc);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_w_valid", {31'b0, W_mul_valid}, 32'd0);
    chk("mrst_w_result", W_mul_result, 32'd0);
    chk("mrst_w_tag", {27'b0, W_mul_tag}, 32'd0);
    chk("mrst_cnt", {16'b0, mul_done_cnt}, 32'd0);
    M_mul_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("mrst_m_ready", {31'b0, M_mul_ready}, 32'd1);
    chk("mrst_no_valid", {31'b0, W_mul_valid}, 32'd0);

    // Back-to-back, writeback always ready
    for (int i = 0; i < 8; i++) begin
      cyc(1, $urandom, $urandom, 5'(i + 10), 1, 0, acc);
      chk("b2b_acc", {31'b0, acc}, 32'd1);
    end
    cyc(0, 0, 0, 0, 1, 0, acc);
    cyc(0, 0, 0, 0, 1, 0, acc);
    chk("b2b_cnt", {16'b0, mul_done_cnt}, 32'd8);

    // Backpressure: 3 offers, writeback stalled for 5 cycles
    for (int i = 0; i < 3; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
    end
    n_acc = 0;
    idx = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(idx < 3, ra[idx % 3], rb[idx % 3], 5'(20 + idx), 0, 0, acc);
      if (acc) begin
        n_acc++;
        idx++;
      end
      if (i == 2) held = W_mul_result;
    end
    chk("bp_accepted", n_acc, 32'd2);
    chk("bp_m_ready", {31'b0, M_mul_ready}, 32'd0);
    chk("bp_hold", W_mul_result, held);
    for (int i = 0; i < 5; i++) begin
      cyc(idx < 3, ra[idx % 3], rb[idx % 3], 5'(20 + idx), 1, 0, acc);
      if (acc) idx++;
    end
    chk("bp_all_in", idx, 32'd3);

    // Flush with both stages full and an input offered in the kill cycle
    cyc(1, $urandom, $urandom, 5'd4, 0, 0, acc);
    cyc(1, $urandom, $urandom, 5'd5, 0, 0, acc);
    chk("fl_full", {31'b0, W_mul_valid}, 32'd1);
    cyc(1, $urandom, $urandom, 5'd6, 0, 1, acc);
    chk("fl_valid", {31'b0, W_mul_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0, acc);
      chk("fl_empty", {31'b0, W_mul_valid}, 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, acc);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, acc);
    chk("sat_final", {28'b0, s_mul_done_cnt}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
